// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the decode hazard controller: address widths, mul/div FSM states.
// No logic of its own; no latency or backpressure.
package pipeline_hazard_controller_pkg;

  localparam int DEFAULT_REG_ADDR_WIDTH = 5;
  localparam int DEFAULT_MULDIV_LATENCY = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // One extra bit over the architectural address selects the physical bank.
  function automatic int phys_addr_width(input int reg_addr_width);
    return reg_addr_width + 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_reg_scoreboard.sv
// Pending-write bit per physical register, with two combinational read ports.
// Updates on the rising clock edge; a set and a clear to the same address resolve to set.
module reg_scoreboard
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int ADDR_W = phys_addr_width(DEFAULT_REG_ADDR_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic              rd_a_pend,
  output logic              rd_b_pend
);

  logic [2**ADDR_W-1:0] pending;

  // The set is written after the clear so it takes precedence on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en) pending[set_addr] <= 1'b1;
    end
  end

  assign rd_a_pend = pending[rd_a_addr];
  assign rd_b_pend = pending[rd_b_addr];

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode issue/stall/bubble decision plus mul/div sequencing; controls are zero-latency combinational.
// A data-cache wait freezes everything and outranks flush, which outranks operand/structural stalls.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter  int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter  int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
  localparam int P              = phys_addr_width(REG_ADDR_WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec_valid,
  input  logic         dec_rs_enable,
  input  logic         dec_rt_enable,
  input  logic [P-1:0] dec_prs_addr,
  input  logic [P-1:0] dec_prt_addr,
  input  logic         dec_wb_reg,
  input  logic [P-1:0] dec_write_addr,
  input  logic         dec_muldiv,
  input  logic         exec_wb_reg,
  input  logic         exec_alu_en,
  input  logic [P-1:0] exec_write_addr,
  input  logic         mem_wb_reg,
  input  logic [P-1:0] mem_write_addr,
  input  logic         wb_wb_reg,
  input  logic [P-1:0] wb_write_addr,
  input  logic         mem_ready,
  input  logic         flush,
  output logic         stall_if,
  output logic         stall_id,
  output logic         bubble_ex,
  output logic         stall_mem,
  output logic         dec_issue,
  output logic         muldiv_busy,
  output logic         muldiv_done
);

  localparam int CNT_W = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 2);

  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;
  logic             md_start;

  logic rs_pend, rt_pend;
  logic rs_fwd, rt_fwd;
  logic rs_load_use, rt_load_use;
  logic data_haz, struct_haz;

  reg_scoreboard #(.ADDR_W(P)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (dec_issue && dec_wb_reg),
    .set_addr  (dec_write_addr),
    .clr_en    (wb_wb_reg),
    .clr_addr  (wb_write_addr),
    .rd_a_addr (dec_prs_addr),
    .rd_b_addr (dec_prt_addr),
    .rd_a_pend (rs_pend),
    .rd_b_pend (rt_pend)
  );

  // A load in exec has no data yet, so it is never a bypass source.
  assign rs_fwd = (exec_wb_reg && exec_alu_en && dec_prs_addr == exec_write_addr) ||
                  (mem_wb_reg && dec_prs_addr == mem_write_addr) ||
                  (wb_wb_reg && dec_prs_addr == wb_write_addr);
  assign rt_fwd = (exec_wb_reg && exec_alu_en && dec_prt_addr == exec_write_addr) ||
                  (mem_wb_reg && dec_prt_addr == mem_write_addr) ||
                  (wb_wb_reg && dec_prt_addr == wb_write_addr);

  assign rs_load_use = exec_wb_reg && !exec_alu_en && dec_prs_addr == exec_write_addr;
  assign rt_load_use = exec_wb_reg && !exec_alu_en && dec_prt_addr == exec_write_addr;

  assign data_haz = (dec_rs_enable && (rs_load_use || (rs_pend && !rs_fwd))) ||
                    (dec_rt_enable && (rt_load_use || (rt_pend && !rt_fwd)));
  assign struct_haz = dec_muldiv && muldiv_busy;

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_mem = 1'b0;
    dec_issue = 1'b0;
    if (!mem_ready) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_mem = 1'b1;
    end else if (flush) begin
      bubble_ex = 1'b1;
    end else if (dec_valid && (data_haz || struct_haz)) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      dec_issue = dec_valid;
    end
  end

  assign md_start = dec_issue && dec_muldiv;

  // Counter is loaded with LATENCY-2 so BUSY spans LATENCY-1 cycles before the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (md_start) begin
            md_cnt   <= CNT_LOAD;
            md_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (md_cnt == '0) md_state <= MD_DONE;
          else              md_cnt   <= md_cnt - CNT_W'(1);
        end
        MD_DONE: begin
          if (md_start) begin
            md_cnt   <= CNT_LOAD;
            md_state <= MD_BUSY;
          end else begin
            md_state <= MD_IDLE;
          end
        end
        default: md_state <= MD_IDLE;
      endcase
    end
  end

  assign muldiv_busy = (md_state == MD_BUSY);
  assign muldiv_done = (md_state == MD_DONE);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scenarios and randomized traffic checked against a cycle-indexed reference model.
module tb_pipeline_hazard_controller;

  localparam int L = 4;
  localparam int P = 6;

  logic         clk, rst;
  logic         dec_valid, dec_rs_enable, dec_rt_enable, dec_wb_reg, dec_muldiv;
  logic [P-1:0] dec_prs_addr, dec_prt_addr, dec_write_addr;
  logic         exec_wb_reg, exec_alu_en, mem_wb_reg, wb_wb_reg, mem_ready, flush;
  logic [P-1:0] exec_write_addr, mem_write_addr, wb_write_addr;
  logic         stall_if, stall_id, bubble_ex, stall_mem, dec_issue, muldiv_busy, muldiv_done;

  logic [6:0] obs;
  assign obs = {stall_if, stall_id, bubble_ex, stall_mem, dec_issue, muldiv_busy, muldiv_done};

  int checks = 0;
  int errors = 0;

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs_enable(dec_rs_enable), .dec_rt_enable(dec_rt_enable),
    .dec_prs_addr(dec_prs_addr), .dec_prt_addr(dec_prt_addr),
    .dec_wb_reg(dec_wb_reg), .dec_write_addr(dec_write_addr), .dec_muldiv(dec_muldiv),
    .exec_wb_reg(exec_wb_reg), .exec_alu_en(exec_alu_en), .exec_write_addr(exec_write_addr),
    .mem_wb_reg(mem_wb_reg), .mem_write_addr(mem_write_addr),
    .wb_wb_reg(wb_wb_reg), .wb_write_addr(wb_write_addr),
    .mem_ready(mem_ready), .flush(flush),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_mem(stall_mem),
    .dec_issue(dec_issue), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending set as a plain array, mul/div tracked by the cycle of its last issue.
  bit pend_m [64];
  int cyc    = 0;
  int md_iss = -1000;

  function automatic bit m_busy();
    return (cyc > md_iss) && (cyc < md_iss + L);
  endfunction

  function automatic bit m_done();
    return cyc == md_iss + L;
  endfunction

  function automatic bit m_haz(input logic en, input logic [P-1:0] a);
    bit fwd, lu;
    fwd = (exec_wb_reg && exec_alu_en && a == exec_write_addr) ||
          (mem_wb_reg && a == mem_write_addr) || (wb_wb_reg && a == wb_write_addr);
    lu  = exec_wb_reg && !exec_alu_en && a == exec_write_addr;
    return en && (lu || (pend_m[a] && !fwd));
  endfunction

  function automatic logic [6:0] m_out();
    logic [4:0] o;
    bit hz;
    hz = m_haz(dec_rs_enable, dec_prs_addr) || m_haz(dec_rt_enable, dec_prt_addr) ||
         (dec_muldiv && m_busy());
    if (!mem_ready)            o = 5'b11010;
    else if (flush)            o = 5'b00100;
    else if (dec_valid && hz)  o = 5'b11100;
    else                       o = {4'b0000, dec_valid};
    return {o, m_busy(), m_done()};
  endfunction

  logic [6:0] m_now;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      md_iss = -1000;
    end else begin
      m_now = m_out();
      if (wb_wb_reg) pend_m[wb_write_addr] = 1'b0;
      if (m_now[2] && dec_wb_reg) pend_m[dec_write_addr] = 1'b1;
      if (m_now[2] && dec_muldiv) md_iss = cyc;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs_enable = 0; dec_rt_enable = 0; dec_wb_reg = 0; dec_muldiv = 0;
    dec_prs_addr = '0; dec_prt_addr = '0; dec_write_addr = '0;
    exec_wb_reg = 0; exec_alu_en = 0; exec_write_addr = '0;
    mem_wb_reg = 0; mem_write_addr = '0; wb_wb_reg = 0; wb_write_addr = '0;
    mem_ready = 1; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL reset_idle: got %b exp %b", obs, 7'b0000000);
    end
    dec_valid = 1; dec_rs_enable = 1; dec_prs_addr = 6'd33;
    #1;
    checks++;
    if (obs !== 7'b0000100) begin
      errors++; $display("FAIL reset_issue_follows_valid: got %b exp %b", obs, 7'b0000100);
    end
    rst = 0;
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle(); dec_valid = 1; dec_wb_reg = 1; dec_write_addr = 6'd7;
    @(negedge clk); checks++;
    if (obs !== 7'b0000100) begin errors++; $display("FAIL load_use_producer: got %b exp %b", obs, 7'b0000100); end
    tick();
    idle(); exec_wb_reg = 1; exec_alu_en = 0; exec_write_addr = 6'd7;
    dec_valid = 1; dec_rs_enable = 1; dec_prs_addr = 6'd7;
    @(negedge clk); checks++;
    if (obs !== 7'b1110000) begin errors++; $display("FAIL load_use_stall: got %b exp %b", obs, 7'b1110000); end
    tick();
    idle(); mem_wb_reg = 1; mem_write_addr = 6'd7;
    dec_valid = 1; dec_rs_enable = 1; dec_prs_addr = 6'd7;
    @(negedge clk); checks++;
    if (obs !== 7'b0000100) begin errors++; $display("FAIL load_use_release: got %b exp %b", obs, 7'b0000100); end
    tick();
    idle(); wb_wb_reg = 1; wb_write_addr = 6'd7;
    tick();
    idle(); dec_valid = 1; dec_rs_enable = 1; dec_prs_addr = 6'd7;
    @(negedge clk); checks++;
    if (obs !== 7'b0000100) begin errors++; $display("FAIL load_use_cleared: got %b exp %b", obs, 7'b0000100); end
    tick();
  endtask

  task automatic test_alu_forward();
    idle(); dec_valid = 1; dec_wb_reg = 1; dec_write_addr = 6'd9;
    tick();
    idle(); exec_wb_reg = 1; exec_alu_en = 1; exec_write_addr = 6'd9;
    dec_valid = 1; dec_rt_enable = 1; dec_prt_addr = 6'd9;
    @(negedge clk); checks++;
    if (obs !== 7'b0000100) begin errors++; $display("FAIL alu_forward: got %b exp %b", obs, 7'b0000100); end
    tick();
    idle(); dec_valid = 1; dec_rt_enable = 1; dec_prt_addr = 6'd9;
    @(negedge clk); checks++;
    if (obs !== 7'b1110000) begin errors++; $display("FAIL pending_no_bypass: got %b exp %b", obs, 7'b1110000); end
    tick();
    idle(); wb_wb_reg = 1; wb_write_addr = 6'd9;
    tick();
    idle();
  endtask

  task automatic test_muldiv_structural();
    logic [6:0] exp;
    for (int c = 0; c <= 9; c++) begin
      idle();
      dec_valid  = (c <= 4);
      dec_muldiv = (c <= 4);
      if (c == 0)      exp = 7'b0000100;
      else if (c <= 3) exp = 7'b1110010;
      else if (c == 4) exp = 7'b0000101;
      else if (c <= 7) exp = 7'b0000010;
      else if (c == 8) exp = 7'b0000001;
      else             exp = 7'b0000000;
      @(negedge clk); checks++;
      if (obs !== exp) begin errors++; $display("FAIL muldiv_struct c%0d: got %b exp %b", c, obs, exp); end
      tick();
    end
  endtask

  task automatic test_long_producer();
    logic [6:0] exp;
    for (int c = 0; c <= 7; c++) begin
      idle();
      dec_valid = 1;
      if (c == 0) begin
        dec_muldiv = 1; dec_wb_reg = 1; dec_write_addr = 6'd40;
      end else begin
        dec_rs_enable = 1; dec_prs_addr = 6'd40;
      end
      if (c == 6) begin wb_wb_reg = 1; wb_write_addr = 6'd40; end
      if (c == 0)      exp = 7'b0000100;
      else if (c <= 3) exp = 7'b1110010;
      else if (c == 4) exp = 7'b1110001;
      else if (c == 5) exp = 7'b1110000;
      else             exp = 7'b0000100;
      @(negedge clk); checks++;
      if (obs !== exp) begin errors++; $display("FAIL long_producer c%0d: got %b exp %b", c, obs, exp); end
      tick();
    end
    idle();
  endtask

  task automatic test_cache_flush();
    for (int c = 0; c < 4; c++) begin
      idle();
      dec_valid = 1; flush = 1; mem_ready = (c == 3);
      wb_wb_reg = 1; wb_write_addr = 6'd12;
      @(negedge clk); checks++;
      if (c < 3 && obs !== 7'b1101000) begin
        errors++; $display("FAIL cache_freeze c%0d: got %b exp %b", c, obs, 7'b1101000);
      end else if (c == 3 && obs !== 7'b0010000) begin
        errors++; $display("FAIL flush_after_wait: got %b exp %b", obs, 7'b0010000);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_op();
    idle(); dec_valid = 1; dec_muldiv = 1; dec_wb_reg = 1; dec_write_addr = 6'd5;
    tick();
    idle();
    @(negedge clk); checks++;
    if (obs !== 7'b0000010) begin errors++; $display("FAIL midop_busy: got %b exp %b", obs, 7'b0000010); end
    rst = 1;
    dec_valid = 1; dec_rs_enable = 1; dec_prs_addr = 6'd5;
    #1; checks++;
    if (obs !== 7'b0000100) begin errors++; $display("FAIL midop_async_clear: got %b exp %b", obs, 7'b0000100); end
    tick();
    rst = 0;
    @(negedge clk); checks++;
    if (obs !== 7'b0000100) begin errors++; $display("FAIL midop_after_reset: got %b exp %b", obs, 7'b0000100); end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int n = 0; n < 400; n++) begin
      dec_valid      = ($urandom_range(0, 99) < 75);
      dec_rs_enable  = ($urandom_range(0, 99) < 70);
      dec_rt_enable  = ($urandom_range(0, 99) < 50);
      dec_prs_addr   = 6'($urandom_range(0, 7));
      dec_prt_addr   = 6'($urandom_range(0, 7));
      dec_wb_reg     = ($urandom_range(0, 99) < 60);
      dec_write_addr = 6'($urandom_range(0, 7));
      dec_muldiv     = ($urandom_range(0, 99) < 20);
      exec_wb_reg    = ($urandom_range(0, 99) < 50);
      exec_alu_en    = ($urandom_range(0, 99) < 60);
      exec_write_addr = 6'($urandom_range(0, 7));
      mem_wb_reg     = ($urandom_range(0, 99) < 40);
      mem_write_addr = 6'($urandom_range(0, 7));
      wb_wb_reg      = ($urandom_range(0, 99) < 40);
      wb_write_addr  = 6'($urandom_range(0, 7));
      mem_ready      = ($urandom_range(0, 99) < 85);
      flush          = ($urandom_range(0, 99) < 8);
      @(negedge clk);
      exp = m_out();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random n%0d: got %b exp %b", n, obs, exp); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_forward();
    test_muldiv_structural();
    test_long_producer();
    test_cache_flush();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
